// File: rtl/core_sequencer_if.sv
// Host/core side signal bundle of the attention-pass sequencer.
// master = host + core side, slave = sequencer.
interface core_sequencer_if #(
    parameter int ADDR_W = 4
);
    localparam int INST_W = 12 + 2 * ADDR_W;

    logic              start;
    logic              abort;
    logic [ADDR_W:0]   n_k;
    logic [ADDR_W:0]   n_q;
    logic              fifo_valid;
    logic [INST_W-1:0] host_inst;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, n_k, n_q, fifo_valid, host_inst,
        input  inst, busy, done, err
    );

    modport slave (
        input  start, abort, n_k, n_q, fifo_valid, host_inst,
        output inst, busy, done, err
    );
endinterface

// File: rtl/core_sequencer.sv
// Drives the core instruction bus through one attention pass:
// kernel load, execute, then per-row drain/normalise into pmem.
module core_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 64
) (
    input logic             clk,
    input logic             reset,
    core_sequencer_if.slave bus
);
    localparam int INST_W = 12 + 2 * ADDR_W;
    localparam int CW     = ADDR_W + 1;
    localparam int TW     = $clog2(TIMEOUT + GAP + 1);
    localparam int OFIFO  = 8 + 2 * ADDR_W;
    localparam int DIV    = 9 + 2 * ADDR_W;
    localparam int ACC    = 10 + 2 * ADDR_W;
    localparam int SFP    = 11 + 2 * ADDR_W;

    localparam logic [CW-1:0] NMAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [INST_W-1:0] RD_W =
        (INST_W'(1) << OFIFO) | (INST_W'(1) << ACC);
    localparam logic [INST_W-1:0] NORM_W = INST_W'(1) << DIV;

    typedef enum logic [3:0] {
        S_IDLE, S_KLOAD, S_GAP, S_EXEC, S_WAITF,
        S_RD, S_NORM, S_WR, S_DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     nk;
    logic [CW-1:0]     nq;
    logic [TW-1:0]     tmo;
    logic [ADDR_W-1:0] row;
    logic [INST_W-1:0] inst_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    function automatic logic [INST_W-1:0] row_word(
        input logic [CW-1:0] a,
        input logic          exec
    );
        logic [INST_W-1:0] w;
        w = '0;
        w[8+ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
        if (exec) begin
            w[5] = 1'b1;
            w[7] = 1'b1;
        end else begin
            w[3] = 1'b1;
            w[6] = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [INST_W-1:0] wr_word(
        input logic [ADDR_W-1:0] r
    );
        logic [INST_W-1:0] w;
        w = '0;
        w[0]          = 1'b1;
        w[SFP]        = 1'b1;
        w[8 +: ADDR_W] = r;
        return w;
    endfunction

    logic start_ok;
    assign start_ok = (bus.n_k != '0) && (bus.n_k <= NMAX) &&
                      (bus.n_q != '0) && (bus.n_q <= NMAX);

    // inst_q always holds the word for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            nk     <= '0;
            nq     <= '0;
            tmo    <= '0;
            row    <= '0;
            inst_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.abort && state != S_IDLE) begin
                state  <= S_IDLE;
                inst_q <= '0;
                busy_q <= 1'b0;
                err_q  <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (bus.start && start_ok) begin
                            state  <= S_KLOAD;
                            nk     <= bus.n_k;
                            nq     <= bus.n_q;
                            cnt    <= '0;
                            inst_q <= row_word('0, 1'b0);
                            busy_q <= 1'b1;
                        end else if (bus.start) begin
                            err_q <= 1'b1;
                        end
                    end
                    S_KLOAD: begin
                        if (cnt == nk - 1'b1) begin
                            state  <= S_GAP;
                            tmo    <= '0;
                            inst_q <= '0;
                        end else begin
                            cnt    <= cnt + 1'b1;
                            inst_q <= row_word(cnt + 1'b1, 1'b0);
                        end
                    end
                    S_GAP: begin
                        if (tmo == TW'(GAP - 1)) begin
                            state  <= S_EXEC;
                            cnt    <= '0;
                            row    <= '0;
                            inst_q <= row_word('0, 1'b1);
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                    S_EXEC: begin
                        if (cnt == nq - 1'b1) begin
                            state  <= S_WAITF;
                            tmo    <= '0;
                            inst_q <= '0;
                        end else begin
                            cnt    <= cnt + 1'b1;
                            inst_q <= row_word(cnt + 1'b1, 1'b1);
                        end
                    end
                    S_WAITF: begin
                        if (bus.fifo_valid) begin
                            state  <= S_RD;
                            tmo    <= '0;
                            inst_q <= RD_W;
                        end else if (tmo == TW'(TIMEOUT - 1)) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                            err_q  <= 1'b1;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                    S_RD: begin
                        state  <= S_NORM;
                        inst_q <= NORM_W;
                    end
                    S_NORM: begin
                        state  <= S_WR;
                        inst_q <= wr_word(row);
                    end
                    S_WR: begin
                        inst_q <= '0;
                        if ({1'b0, row} == nq - 1'b1) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_WAITF;
                            row   <= row + 1'b1;
                            tmo   <= '0;
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        inst_q <= '0;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        inst_q <= '0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.inst = (state == S_IDLE) ? bus.host_inst : inst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: expected non-zero bus words
// are queued at start and popped as the sequencer emits them.
module tb_core_sequencer;
    localparam int A  = 4;
    localparam int IW = 12 + 2 * A;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    core_sequencer_if #(.ADDR_W(A)) bus ();

    core_sequencer #(
        .ADDR_W (A),
        .GAP    (2),
        .TIMEOUT(64)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] w_row(input int a, input bit ex);
        logic [IW-1:0] w;
        w = '0;
        w[8+A +: A] = a[A-1:0];
        if (ex) begin
            w[5] = 1'b1;
            w[7] = 1'b1;
        end else begin
            w[3] = 1'b1;
            w[6] = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [IW-1:0] w_rd();
        logic [IW-1:0] w;
        w = '0;
        w[8+2*A]  = 1'b1;
        w[10+2*A] = 1'b1;
        return w;
    endfunction

    function automatic logic [IW-1:0] w_norm();
        logic [IW-1:0] w;
        w = '0;
        w[9+2*A] = 1'b1;
        return w;
    endfunction

    function automatic logic [IW-1:0] w_wr(input int r);
        logic [IW-1:0] w;
        w = '0;
        w[0]       = 1'b1;
        w[11+2*A]  = 1'b1;
        w[8 +: A]  = r[A-1:0];
        return w;
    endfunction

    logic [IW-1:0] sb[$];

    int cyc       = 0;
    int start_cyc = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int err_cnt   = 0;
    int err_cyc   = 0;
    int zero_cnt  = 0;
    int wr_seen   = 0;
    int bp_k      = 0;
    bit fv_hold   = 1'b1;
    bit bp_arm    = 1'b0;
    bit abort_arm = 1'b0;

    task automatic push_pass(input int nk, input int nq);
        for (int i = 0; i < nk; i++) sb.push_back(w_row(i, 1'b0));
        for (int i = 0; i < nq; i++) sb.push_back(w_row(i, 1'b1));
        for (int r = 0; r < nq; r++) begin
            sb.push_back(w_rd());
            sb.push_back(w_norm());
            sb.push_back(w_wr(r));
        end
    endtask

    // Monitor: samples on the falling edge, owns fifo_valid/abort.
    always @(negedge clk) begin
        cyc++;
        bus.abort = 1'b0;
        if (bp_k > 0) bp_k--;
        bus.fifo_valid = (bp_k == 0) ? fv_hold : 1'b0;
        if (bus.start && !bus.busy) begin
            start_cyc = cyc;
            wr_seen   = 0;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (bus.busy) begin
            if (bus.inst == '0) begin
                zero_cnt++;
            end else begin
                if (sb.size() == 0)
                    check("sb_extra", 32'(bus.inst), 32'd0);
                else
                    check("inst", 32'(bus.inst), 32'(sb.pop_front()));
                if (abort_arm && wr_seen == 2 && bus.inst == w_norm()) begin
                    bus.abort = 1'b1;
                    abort_arm = 1'b0;
                end
                if (bp_arm && bus.inst == w_wr(2)) begin
                    bp_arm = 1'b0;
                    bp_k   = 11;
                    bus.fifo_valid = 1'b0;
                end
                if (bus.inst[0]) wr_seen++;
            end
        end
    end

    task automatic pulse_start(input int nk, input int nq);
        @(posedge clk);
        #1;
        bus.n_k   = (A+1)'(nk);
        bus.n_q   = (A+1)'(nq);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && bus.busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("idle_bound", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input string tag, input int nk, input int nq,
                            input int lat, input int zeros);
        int d0, e0, z0;
        d0 = done_cnt;
        e0 = err_cnt;
        z0 = zero_cnt;
        push_pass(nk, nq);
        pulse_start(nk, nq);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_idle(400);
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_err"}, err_cnt - e0, 0);
        check({tag, "_lat"}, done_cyc - start_cyc, lat);
        check({tag, "_zero"}, zero_cnt - z0, zeros);
        check({tag, "_sb"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.n_k       = '0;
        bus.n_q       = '0;
        bus.host_inst = 20'h00014;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_inst", 32'(bus.inst), 32'h00014);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("host_fwd", 32'(bus.inst), 32'h00014);
        bus.host_inst = 20'habcde;
        #1;
        check("host_fwd2", 32'(bus.inst), 32'habcde);
        check("idle_busy", 32'(bus.busy), 32'd0);

        run_pass("nom", 8, 8, 51, 11);
        run_pass("max", 16, 16, 99, 19);
        run_pass("min", 1, 1, 9, 4);

        bp_arm = 1'b1;
        run_pass("bp", 8, 8, 61, 21);

        // fifo_valid stuck low: only kload/exec words reach the bus
        d0 = done_cnt;
        e0 = err_cnt;
        fv_hold = 1'b0;
        sb.push_back(w_row(0, 1'b0));
        sb.push_back(w_row(0, 1'b1));
        pulse_start(1, 1);
        wait_idle(200);
        check("to_err", err_cnt - e0, 1);
        check("to_done", done_cnt - d0, 0);
        check("to_lat", err_cyc - start_cyc, 69);
        check("to_sb", sb.size(), 0);
        sb.delete();
        fv_hold = 1'b1;
        repeat (2) @(posedge clk);

        e0 = err_cnt;
        pulse_start(8, 0);
        check("bad_nq_busy", 32'(bus.busy), 32'd0);
        pulse_start(17, 4);
        check("bad_nk_busy", 32'(bus.busy), 32'd0);
        pulse_start(0, 4);
        repeat (2) @(posedge clk);
        #1;
        check("bad_err", err_cnt - e0, 3);
        check("bad_busy", 32'(bus.busy), 32'd0);

        // start during EXEC must be ignored
        d0 = done_cnt;
        e0 = err_cnt;
        push_pass(8, 8);
        pulse_start(8, 8);
        for (int i = 0; i < 40 && !bus.inst[7]; i++) begin
            @(posedge clk);
            #1;
        end
        check("in_exec", 32'(bus.inst[7]), 32'd1);
        pulse_start(3, 3);
        wait_idle(200);
        check("bs_done", done_cnt - d0, 1);
        check("bs_err", err_cnt - e0, 0);
        check("bs_lat", done_cyc - start_cyc, 51);
        check("bs_sb", sb.size(), 0);
        sb.delete();

        // abort in NORM of row 2: row 2 write never issued
        d0 = done_cnt;
        e0 = err_cnt;
        abort_arm = 1'b1;
        push_pass(8, 4);
        pulse_start(8, 4);
        wait_idle(200);
        check("ab_err", err_cnt - e0, 1);
        check("ab_done", done_cnt - d0, 0);
        check("ab_left", sb.size(), 4);
        check("ab_wr2", 32'(sb[0]), 32'(w_wr(2)));
        sb.delete();

        // asynchronous reset mid KLOAD
        d0 = done_cnt;
        e0 = err_cnt;
        push_pass(8, 8);
        pulse_start(8, 8);
        @(posedge clk);
        #1;
        check("kl_mid", 32'(bus.inst), 32'(w_row(1, 1'b0)));
        bus.host_inst = 20'h12345;
        #2;
        reset = 1'b1;
        #1;
        check("ar_inst", 32'(bus.inst), 32'h12345);
        check("ar_busy", 32'(bus.busy), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ar_done", done_cnt - d0, 0);
        check("ar_err", err_cnt - e0, 0);
        check("ar_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
